// File: rtl/alu_rs_if.sv
// Dispatch, result-broadcast and issue signals of the ALU reservation station.
interface alu_rs_if #(parameter int ROB_WIDTH = 4);
    logic                 rdy;
    logic                 rollback_config;
    logic                 in_config;
    logic [6:0]           in_opcode;
    logic [2:0]           in_precise;
    logic                 in_more_precise;
    logic [31:0]          in_PC;
    logic [31:0]          in_imm;
    logic [ROB_WIDTH-1:0] in_rob_entry;
    logic                 in_qj_busy;
    logic [ROB_WIDTH-1:0] in_qj;
    logic [31:0]          in_vj;
    logic                 in_qk_busy;
    logic [ROB_WIDTH-1:0] in_qk;
    logic [31:0]          in_vk;
    logic                 alu_cdb_config;
    logic [ROB_WIDTH-1:0] alu_cdb_rob_entry;
    logic [31:0]          alu_cdb_val;
    logic                 lsb_cdb_config;
    logic [ROB_WIDTH-1:0] lsb_cdb_rob_entry;
    logic [31:0]          lsb_cdb_val;
    logic                 out_config;
    logic [31:0]          out_a;
    logic [31:0]          out_b;
    logic [31:0]          out_PC;
    logic [31:0]          out_imm;
    logic [6:0]           out_opcode;
    logic [2:0]           out_precise;
    logic                 out_more_precise;
    logic [ROB_WIDTH-1:0] out_rob_entry;
    logic                 out_full;

    modport master (
        output rdy, rollback_config, in_config, in_opcode, in_precise, in_more_precise,
               in_PC, in_imm, in_rob_entry, in_qj_busy, in_qj, in_vj, in_qk_busy, in_qk, in_vk,
               alu_cdb_config, alu_cdb_rob_entry, alu_cdb_val,
               lsb_cdb_config, lsb_cdb_rob_entry, lsb_cdb_val,
        input  out_config, out_a, out_b, out_PC, out_imm, out_opcode, out_precise,
               out_more_precise, out_rob_entry, out_full
    );

    modport slave (
        input  rdy, rollback_config, in_config, in_opcode, in_precise, in_more_precise,
               in_PC, in_imm, in_rob_entry, in_qj_busy, in_qj, in_vj, in_qk_busy, in_qk, in_vk,
               alu_cdb_config, alu_cdb_rob_entry, alu_cdb_val,
               lsb_cdb_config, lsb_cdb_rob_entry, lsb_cdb_val,
        output out_config, out_a, out_b, out_PC, out_imm, out_opcode, out_precise,
               out_more_precise, out_rob_entry, out_full
    );
endinterface

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: holds dispatched ops until both operands resolve, issues lowest ready.
// Latency: ready-to-issue one cycle; out_full is combinational; rdy=0 freezes everything.
module alu_rs_scheduler #(
    parameter int RS_SIZE   = 8,
    parameter int ROB_WIDTH = 4
) (
    input logic   clk,
    input logic   rst_n,
    alu_rs_if.slave bus
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    typedef struct packed {
        logic                 valid;
        logic [6:0]           opcode;
        logic [2:0]           precise;
        logic                 more_precise;
        logic [31:0]          pc;
        logic [31:0]          imm;
        logic [ROB_WIDTH-1:0] rob;
        logic                 qj_busy;
        logic [ROB_WIDTH-1:0] qj;
        logic [31:0]          vj;
        logic                 qk_busy;
        logic [ROB_WIDTH-1:0] qk;
        logic [31:0]          vk;
    } entry_t;

    entry_t             ents [RS_SIZE];
    logic [RS_SIZE-1:0] valid_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   rdy_idx;
    logic               has_free;
    logic               has_ready;
    logic [32:0]        j_snoop [RS_SIZE];
    logic [32:0]        k_snoop [RS_SIZE];
    entry_t             new_ent;

    logic                 alu_v, lsb_v;
    logic [ROB_WIDTH-1:0] alu_t, lsb_t;
    logic [31:0]          alu_d, lsb_d;
    assign alu_v = bus.alu_cdb_config;
    assign alu_t = bus.alu_cdb_rob_entry;
    assign alu_d = bus.alu_cdb_val;
    assign lsb_v = bus.lsb_cdb_config;
    assign lsb_t = bus.lsb_cdb_rob_entry;
    assign lsb_d = bus.lsb_cdb_val;

    // Returns {busy, value} after snooping both buses; ALU wins on a tag collision.
    function automatic logic [32:0] snoop(input logic busy, input logic [ROB_WIDTH-1:0] tag,
                                          input logic [31:0] val);
        if (busy && alu_v && alu_t == tag)      return {1'b0, alu_d};
        else if (busy && lsb_v && lsb_t == tag) return {1'b0, lsb_d};
        else                                    return {busy, val};
    endfunction

    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        free_idx  = '0;
        rdy_idx   = '0;
        has_free  = 1'b0;
        has_ready = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            valid_vec[i] = ents[i].valid;
            ready_vec[i] = ents[i].valid && !ents[i].qj_busy && !ents[i].qk_busy;
            j_snoop[i]   = snoop(ents[i].qj_busy, ents[i].qj, ents[i].vj);
            k_snoop[i]   = snoop(ents[i].qk_busy, ents[i].qk, ents[i].vk);
        end
        // Scan downward so the lowest index is the one left standing.
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                free_idx = IDX_W'(i);
                has_free = 1'b1;
            end
            if (ready_vec[i]) begin
                rdy_idx   = IDX_W'(i);
                has_ready = 1'b1;
            end
        end
    end

    always_comb begin
        new_ent              = '0;
        new_ent.valid        = 1'b1;
        new_ent.opcode       = bus.in_opcode;
        new_ent.precise      = bus.in_precise;
        new_ent.more_precise = bus.in_more_precise;
        new_ent.pc           = bus.in_PC;
        new_ent.imm          = bus.in_imm;
        new_ent.rob          = bus.in_rob_entry;
        new_ent.qj           = bus.in_qj;
        new_ent.qk           = bus.in_qk;
        {new_ent.qj_busy, new_ent.vj} = snoop(bus.in_qj_busy, bus.in_qj, bus.in_vj);
        {new_ent.qk_busy, new_ent.vk} = snoop(bus.in_qk_busy, bus.in_qk, bus.in_vk);
    end

    assign bus.out_full = &valid_vec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_SIZE; i++) ents[i] <= '0;
            bus.out_config       <= 1'b0;
            bus.out_a            <= '0;
            bus.out_b            <= '0;
            bus.out_PC           <= '0;
            bus.out_imm          <= '0;
            bus.out_opcode       <= '0;
            bus.out_precise      <= '0;
            bus.out_more_precise <= 1'b0;
            bus.out_rob_entry    <= '0;
        end else if (bus.rollback_config) begin
            for (int i = 0; i < RS_SIZE; i++) ents[i].valid <= 1'b0;
            bus.out_config <= 1'b0;
        end else if (bus.rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ents[i].valid) begin
                    {ents[i].qj_busy, ents[i].vj} <= j_snoop[i];
                    {ents[i].qk_busy, ents[i].vk} <= k_snoop[i];
                end
            end
            if (has_ready) begin
                ents[rdy_idx].valid  <= 1'b0;
                bus.out_config       <= 1'b1;
                bus.out_a            <= ents[rdy_idx].vj;
                bus.out_b            <= ents[rdy_idx].vk;
                bus.out_PC           <= ents[rdy_idx].pc;
                bus.out_imm          <= ents[rdy_idx].imm;
                bus.out_opcode       <= ents[rdy_idx].opcode;
                bus.out_precise      <= ents[rdy_idx].precise;
                bus.out_more_precise <= ents[rdy_idx].more_precise;
                bus.out_rob_entry    <= ents[rdy_idx].rob;
            end else begin
                bus.out_config <= 1'b0;
            end
            // free_idx comes from registered valids, so the slot issuing now is never reused here.
            if (bus.in_config && has_free) ents[free_idx] <= new_ent;
        end
    end
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Bench for alu_rs_scheduler: vector table of ready ops plus wakeup/full/rollback/rdy sequences.
module tb_alu_rs_scheduler;
    logic clk;
    logic rst_n;
    alu_rs_if #(.ROB_WIDTH(4)) bus ();

    alu_rs_scheduler #(.RS_SIZE(8), .ROB_WIDTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        more;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [3:0]  rob;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        more;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [3:0]  rob;
        logic [31:0] vj;
        logic [31:0] vk;
        exp_t        e;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t last_exp;
    exp_t ex;
    vec_t vecs [5];

    function automatic exp_t act();
        return {bus.out_opcode, bus.out_precise, bus.out_more_precise, bus.out_PC,
                bus.out_imm, bus.out_rob_entry, bus.out_a, bus.out_b};
    endfunction

    task automatic chk(input string name, input logic [142:0] got, input logic [142:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Advance one edge, then score any issue against the head of the expected queue.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.out_config) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_issue rob=%0d a=%h", bus.out_rob_entry, bus.out_a);
            end else begin
                last_exp = q.pop_front();
                chk("issue", act(), last_exp);
            end
        end
    endtask

    task automatic clr_in();
        bus.in_config = 0; bus.in_opcode = 0; bus.in_precise = 0; bus.in_more_precise = 0;
        bus.in_PC = 0; bus.in_imm = 0; bus.in_rob_entry = 0;
        bus.in_qj_busy = 0; bus.in_qj = 0; bus.in_vj = 0;
        bus.in_qk_busy = 0; bus.in_qk = 0; bus.in_vk = 0;
        bus.alu_cdb_config = 0; bus.alu_cdb_rob_entry = 0; bus.alu_cdb_val = 0;
        bus.lsb_cdb_config = 0; bus.lsb_cdb_rob_entry = 0; bus.lsb_cdb_val = 0;
    endtask

    task automatic disp(input logic [6:0] op, input logic [2:0] f3, input logic more,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] rob,
                        input logic qjb, input logic [3:0] qj, input logic [31:0] vj,
                        input logic qkb, input logic [3:0] qk, input logic [31:0] vk);
        bus.in_config = 1; bus.in_opcode = op; bus.in_precise = f3; bus.in_more_precise = more;
        bus.in_PC = pc; bus.in_imm = imm; bus.in_rob_entry = rob;
        bus.in_qj_busy = qjb; bus.in_qj = qj; bus.in_vj = vj;
        bus.in_qk_busy = qkb; bus.in_qk = qk; bus.in_vk = vk;
    endtask

    task automatic alu_bc(input logic v, input logic [3:0] t, input logic [31:0] d);
        bus.alu_cdb_config = v; bus.alu_cdb_rob_entry = t; bus.alu_cdb_val = d;
    endtask

    task automatic lsb_bc(input logic v, input logic [3:0] t, input logic [31:0] d);
        bus.lsb_cdb_config = v; bus.lsb_cdb_rob_entry = t; bus.lsb_cdb_val = d;
    endtask

    initial begin
        vecs[0] = '{7'b0110011, 3'd0, 1'b0, 32'h100, 32'h0, 4'd3, 32'd5, 32'd7,
                    '{7'b0110011, 3'd0, 1'b0, 32'h100, 32'h0, 4'd3, 32'd5, 32'd7}};
        vecs[1] = '{7'b0110011, 3'd0, 1'b1, 32'h104, 32'h0, 4'd4, 32'h20, 32'h8,
                    '{7'b0110011, 3'd0, 1'b1, 32'h104, 32'h0, 4'd4, 32'h20, 32'h8}};
        vecs[2] = '{7'b0110111, 3'd0, 1'b0, 32'h108, 32'h12345000, 4'd5, 32'h0, 32'h0,
                    '{7'b0110111, 3'd0, 1'b0, 32'h108, 32'h12345000, 4'd5, 32'h0, 32'h0}};
        vecs[3] = '{7'b1100011, 3'd0, 1'b0, 32'h200, 32'hFFFFFFF8, 4'd6, 32'hDEADBEEF, 32'hDEADBEEF,
                    '{7'b1100011, 3'd0, 1'b0, 32'h200, 32'hFFFFFFF8, 4'd6, 32'hDEADBEEF, 32'hDEADBEEF}};
        vecs[4] = '{7'b0010011, 3'd5, 1'b1, 32'h20C, 32'h3, 4'd7, 32'h80000000, 32'h0,
                    '{7'b0010011, 3'd5, 1'b1, 32'h20C, 32'h3, 4'd7, 32'h80000000, 32'h0}};

        clk = 0; rst_n = 0;
        clr_in();
        bus.rdy = 1; bus.rollback_config = 0;

        // Reset holds off dispatch even with in_config high.
        disp(vecs[0].op, vecs[0].f3, vecs[0].more, vecs[0].pc, vecs[0].imm, vecs[0].rob,
             0, 0, vecs[0].vj, 0, 0, vecs[0].vk);
        tick(); tick();
        chk("rst_out_config", bus.out_config, 0);
        chk("rst_out_full", bus.out_full, 0);
        chk("rst_outputs", act(), 0);
        rst_n = 1;
        q.push_back(vecs[0].e);
        tick();
        bus.in_config = 0;
        chk("rst_rel_lat0", bus.out_config, 0);
        tick();
        chk("rst_rel_lat1", bus.out_config, 1);
        tick();
        chk("rst_rel_lat2", bus.out_config, 0);

        for (int i = 0; i < 5; i++) begin
            disp(vecs[i].op, vecs[i].f3, vecs[i].more, vecs[i].pc, vecs[i].imm, vecs[i].rob,
                 0, 0, vecs[i].vj, 0, 0, vecs[i].vk);
            q.push_back(vecs[i].e);
            tick();
            bus.in_config = 0;
            chk("vec_lat0", bus.out_config, 0);
            tick();
            chk("vec_lat1", bus.out_config, 1);
            tick();
            chk("vec_lat2", bus.out_config, 0);
        end
        chk("vec_drain", q.size(), 0);

        // Wakeup from the ALU bus three cycles after dispatch.
        disp(7'b0110011, 3'd0, 1'b0, 32'h400, 32'h0, 4'd11, 1, 4'd2, 32'h0, 0, 4'd0, 32'd9);
        tick();
        clr_in();
        tick(); tick();
        ex = '{7'b0110011, 3'd0, 1'b0, 32'h400, 32'h0, 4'd11, 32'h10, 32'd9};
        q.push_back(ex);
        alu_bc(1, 4'd2, 32'h10);
        tick();
        clr_in();
        chk("wake_lat0", bus.out_config, 0);
        tick();
        chk("wake_lat1", bus.out_config, 1);

        // Dispatch coincident with an LSB broadcast of the k producer.
        disp(7'b0110011, 3'd7, 1'b0, 32'h404, 32'h0, 4'd12, 0, 4'd0, 32'd1, 1, 4'd6, 32'h0);
        lsb_bc(1, 4'd6, 32'hABCD);
        ex = '{7'b0110011, 3'd7, 1'b0, 32'h404, 32'h0, 4'd12, 32'd1, 32'hABCD};
        q.push_back(ex);
        tick();
        clr_in();
        tick();
        chk("bypass_lat1", bus.out_config, 1);

        // Both buses carry the same tag: ALU value must win.
        disp(7'b0110011, 3'd0, 1'b0, 32'h408, 32'h0, 4'd13, 1, 4'd4, 32'h0, 0, 4'd0, 32'd2);
        tick();
        clr_in();
        alu_bc(1, 4'd4, 32'hA1);
        lsb_bc(1, 4'd4, 32'hB2);
        ex = '{7'b0110011, 3'd0, 1'b0, 32'h408, 32'h0, 4'd13, 32'hA1, 32'd2};
        q.push_back(ex);
        tick();
        clr_in();
        tick();
        chk("prio_drain", q.size(), 0);

        // Fill every slot with a pending op waiting on tag 8+i.
        for (int i = 0; i < 8; i++) begin
            disp(7'b0110011, 3'd0, 1'b0, 32'h300 + 32'(4 * i), 32'h0, 4'(i),
                 1, 4'(8 + i), 32'h0, 0, 4'd0, 32'(100 + i));
            tick();
        end
        clr_in();
        chk("full_set", bus.out_full, 1);
        disp(7'b0110011, 3'd0, 1'b0, 32'h3F0, 32'h0, 4'd15, 0, 4'd0, 32'd1, 0, 4'd0, 32'd1);
        tick();
        clr_in();
        tick();
        chk("full_drop", bus.out_full, 1);
        alu_bc(1, 4'd13, 32'h55);
        lsb_bc(1, 4'd9, 32'h11);
        ex = '{7'b0110011, 3'd0, 1'b0, 32'h304, 32'h0, 4'd1, 32'h11, 32'd101};
        q.push_back(ex);
        ex = '{7'b0110011, 3'd0, 1'b0, 32'h314, 32'h0, 4'd5, 32'h55, 32'd105};
        q.push_back(ex);
        tick();
        clr_in();
        chk("order_lat0", bus.out_config, 0);
        chk("order_full_hold", bus.out_full, 1);
        tick();
        chk("order_full_drop", bus.out_full, 0);
        tick();
        chk("order_second", bus.out_config, 1);
        tick();
        chk("order_drain", q.size(), 0);

        // Rollback with rdy low and a simultaneous ready dispatch: everything vanishes.
        bus.rdy = 0;
        bus.rollback_config = 1;
        disp(7'b0110011, 3'd0, 1'b0, 32'h500, 32'h0, 4'd14, 0, 4'd0, 32'd3, 0, 4'd0, 32'd4);
        tick();
        clr_in();
        bus.rollback_config = 0;
        bus.rdy = 1;
        chk("rb_out_config", bus.out_config, 0);
        chk("rb_out_full", bus.out_full, 0);
        for (int i = 0; i < 8; i++) begin
            alu_bc(1, 4'(8 + i), 32'hEE);
            tick();
        end
        clr_in();
        tick(); tick();
        chk("rb_drain", q.size(), 0);

        // rdy low for three cycles: no issue, outputs frozen, broadcast lost.
        disp(7'b0110011, 3'd0, 1'b0, 32'h600, 32'h0, 4'd9, 1, 4'd2, 32'h0, 0, 4'd0, 32'd1);
        tick();
        disp(7'b0110011, 3'd1, 1'b0, 32'h604, 32'h0, 4'd10, 0, 4'd0, 32'h77, 0, 4'd0, 32'h88);
        tick();
        clr_in();
        bus.rdy = 0;
        alu_bc(1, 4'd2, 32'h99);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rdy_no_issue", bus.out_config, 0);
            chk("rdy_frozen", act(), last_exp);
        end
        bus.rdy = 1;
        clr_in();
        ex = '{7'b0110011, 3'd1, 1'b0, 32'h604, 32'h0, 4'd10, 32'h77, 32'h88};
        q.push_back(ex);
        tick();
        chk("rdy_issue", bus.out_config, 1);
        tick(); tick(); tick();
        chk("rdy_drain", q.size(), 0);
        chk("rdy_full", bus.out_full, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
